// File: rtl/prog_loader_if.sv
// Byte-stream and program-memory write port between the boot loader and its surroundings.
// The slave modport is the loader side; master is the stream source / memory side.
interface prog_loader_if #(
  parameter int ADDR_W = 10
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader: framed byte stream -> 32-bit program words, core held in reset
// until a complete image with a matching XOR checksum has been written.
//   state | meaning
//   IDLE  | waiting for start after reset
//   LEN0  | expecting word-count low byte
//   LEN1  | expecting word-count high byte, length is validated here
//   DATA  | assembling little-endian words, one memory write per word
//   CHK   | expecting checksum byte
//   DONE  | load finished (done or error), outputs held until next start
module prog_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  prog_loader_if.slave bus,
  output logic         core_rst_n,
  output logic         busy,
  output logic         done,
  output logic         error
);
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CHK, DONE} state_t;

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_t      state, state_nxt;
  logic [7:0]  len_lo;
  logic [7:0]  csum;
  logic [15:0] len;
  logic [15:0] len_new;
  logic [15:0] word_idx;
  logic [1:0]  lane;
  logic [23:0] asm_word;
  logic        ready;
  logic        xfer;
  logic        len_bad;
  logic        last_word;

  always_comb begin
    ready     = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CHK);
    xfer      = bus.byte_valid && ready;
    len_new   = {bus.byte_data, len_lo};
    len_bad   = (len_new == 16'd0) || ({1'b0, len_new} > MAX_N);
    last_word = (lane == 2'd3) && (word_idx == len - 16'd1);
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LEN0;
      LEN0:    if (xfer) state_nxt = LEN1;
      LEN1:    if (xfer) state_nxt = len_bad ? DONE : DATA;
      DATA:    if (xfer && last_word) state_nxt = CHK;
      CHK:     if (xfer) state_nxt = DONE;
      DONE:    if (start) state_nxt = LEN0;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.byte_ready = ready;
  assign busy           = ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      len_lo        <= '0;
      len           <= '0;
      word_idx      <= '0;
      lane          <= '0;
      asm_word      <= '0;
      csum          <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      core_rst_n    <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      state      <= state_nxt;
      bus.mem_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            csum       <= '0;
            word_idx   <= '0;
            lane       <= '0;
            error      <= 1'b0;
            done       <= 1'b0;
            core_rst_n <= 1'b0;
          end
        end
        LEN0: if (xfer) len_lo <= bus.byte_data;
        LEN1: begin
          if (xfer) begin
            len <= len_new;
            if (len_bad) error <= 1'b1;
          end
        end
        DATA: begin
          if (xfer) begin
            csum     <= csum ^ bus.byte_data;
            lane     <= lane + 2'd1;
            // shift register ends up holding bytes 2,1,0 when the last lane arrives
            asm_word <= {bus.byte_data, asm_word[23:8]};
            if (lane == 2'd3) begin
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= word_idx[ADDR_W-1:0];
              bus.mem_wdata <= {bus.byte_data, asm_word};
              word_idx      <= word_idx + 16'd1;
            end
          end
        end
        CHK: begin
          if (xfer) begin
            if (bus.byte_data == csum) begin
              done       <= 1'b1;
              core_rst_n <= 1'b1;
            end else begin
              error <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
